sb_tx_arbiter: RTL and testbench

//  Shares the single sideband serializer between N_REQ byte-stream requesters (LT, AT, ordered-set engines).

---
 rtl/sb_tx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sb_tx_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter
// Shares one sideband serializer between N_REQ byte-stream requesters.
// A round-robin winner is locked for a whole packet; every byte leaves as a
// 10-bit symbol {stop=1, data[7:0], start=0} so the serializer, shifting LSB
// first, emits the start bit and then the data LSB first. Each packet is
// followed by GAP_CYCLES idle cycles, and a granted requester that stalls
// mid-packet for TIMEOUT cycles is aborted with a one-cycle timeout_err pulse.
module sb_tx_arbiter #(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 10,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ*8-1:0] in_data,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [N_REQ-1:0]   in_last,
  output logic [N_REQ-1:0]   in_ready,
  output logic [N_REQ-1:0]   gnt,
  output logic [9:0]         sym_data,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic               busy,
  output logic               timeout_err
);

  // Counter widths: the gap counter runs 0..GAP_CYCLES-1 and the stall
  // counter 0..TIMEOUT-1, so neither needs to hold its terminal value.
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic [IDX_W-1:0]   last_gnt_reg, last_gnt_next;
  logic [9:0]         sym_data_reg, sym_data_next;
  logic               sym_valid_reg, sym_valid_next;
  logic               last_q_reg, last_q_next;
  logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               timeout_err_reg, timeout_err_next;

  // Per-requester byte lanes and round-robin masking
  logic [7:0]         req_byte [N_REQ];
  logic [N_REQ-1:0]   hi_mask;
  logic [N_REQ-1:0]   hi_req;
  logic [N_REQ-1:0]   pick_vec;
  logic [IDX_W-1:0]   win_idx;
  logic               req_any;

  // Handshake helpers for the granted requester (index kept in last_gnt_reg)
  logic               send_open;
  logic               byte_acc;
  logic               sym_done;
  logic               stall;
  logic [7:0]         cur_byte;
  logic               cur_valid;
  logic               cur_last;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign req_byte[gi] = in_data[gi*8 +: 8];
    // Indices strictly above the previous winner get first look.
    assign hi_mask[gi]  = (IDX_W'(gi) > last_gnt_reg);
    // Only the granted lane can see a ready, and only while a slot is open.
    assign in_ready[gi] = send_open && (last_gnt_reg == IDX_W'(gi));
  end

  assign hi_req   = in_valid & hi_mask;
  assign pick_vec = (|hi_req) ? hi_req : in_valid;
  assign req_any  = |in_valid;

  // Lowest set bit of the rotated request vector is the round-robin winner.
  always_comb begin
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) begin
        win_idx = IDX_W'(i);
      end
    end
  end

  assign cur_byte  = req_byte[last_gnt_reg];
  assign cur_valid = in_valid[last_gnt_reg];
  assign cur_last  = in_last[last_gnt_reg];

  // The output slot is free when empty or draining this cycle; once the last
  // byte of the packet sits in the slot no further byte is taken, so the next
  // packet of the same requester has to win arbitration again.
  assign send_open = (state_reg == ST_SEND) && !(sym_valid_reg && last_q_reg) &&
                     (!sym_valid_reg || sym_ready);
  assign byte_acc  = send_open && cur_valid;
  assign sym_done  = sym_valid_reg && sym_ready && last_q_reg;
  // Only a starved slot counts as a stall; backpressure keeps sym_valid high.
  assign stall     = !sym_valid_reg && !cur_valid;

  // Next-state and datapath decisions for the arbiter FSM
  always_comb begin
    state_next       = state_reg;
    gnt_next         = gnt_reg;
    last_gnt_next    = last_gnt_reg;
    sym_data_next    = sym_data_reg;
    sym_valid_next   = sym_valid_reg;
    last_q_next      = last_q_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    timeout_err_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_any) begin
          state_next        = ST_SEND;
          gnt_next          = '0;
          gnt_next[win_idx] = 1'b1;
          last_gnt_next     = win_idx;
          tmo_cnt_next      = '0;
          last_q_next       = 1'b0;
        end
      end

      ST_SEND: begin
        if (byte_acc) begin
          sym_data_next  = {1'b1, cur_byte, 1'b0};
          sym_valid_next = 1'b1;
          last_q_next    = cur_last;
          tmo_cnt_next   = '0;
        end else if (sym_valid_reg && sym_ready) begin
          sym_valid_next = 1'b0;
        end

        if (sym_done) begin
          gnt_next     = '0;
          last_q_next  = 1'b0;
          tmo_cnt_next = '0;
          gap_cnt_next = '0;
          state_next   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else if (stall) begin
          if (tmo_cnt_reg == TMO_W'(TMO_LAST)) begin
            timeout_err_next = 1'b1;
            gnt_next         = '0;
            last_q_next      = 1'b0;
            tmo_cnt_next     = '0;
            gap_cnt_next     = '0;
            state_next       = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_LAST)) begin
          gap_cnt_next = '0;
          state_next   = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        gnt_next       = '0;
        sym_valid_next = 1'b0;
        last_q_next    = 1'b0;
      end
    endcase
  end

  // State register; reset drops any pending symbol and points the
  // round-robin pointer at the highest index so requester 0 goes first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      gnt_reg         <= '0;
      last_gnt_reg    <= IDX_W'(N_REQ - 1);
      sym_data_reg    <= '0;
      sym_valid_reg   <= 1'b0;
      last_q_reg      <= 1'b0;
      tmo_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      last_gnt_reg    <= last_gnt_next;
      sym_data_reg    <= sym_data_next;
      sym_valid_reg   <= sym_valid_next;
      last_q_reg      <= last_q_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign gnt         = gnt_reg;
  assign sym_data    = sym_data_reg;
  assign sym_valid   = sym_valid_reg;
  assign timeout_err = timeout_err_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Testbench for sb_tx_arbiter: directed scenarios plus a randomized packet run
// checked against a round-robin packet scoreboard.
module tb_sb_tx_arbiter;

  localparam int N   = 3;
  localparam int GAP = 10;
  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic [N*8-1:0] in_data;
  logic [N-1:0]  in_valid, in_last, in_ready, gnt;
  logic [9:0]    sym_data;
  logic          sym_valid, sym_ready, busy, timeout_err;

  logic [N*8-1:0] z_in_data;
  logic [N-1:0]  z_in_valid, z_in_last, z_in_ready, z_gnt;
  logic [9:0]    z_sym_data;
  logic          z_sym_valid, z_sym_ready, z_busy, z_timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  sb_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .gnt(gnt), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .busy(busy), .timeout_err(timeout_err)
  );

  sb_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_dut_nogap (
    .clk(clk), .rst(rst), .in_data(z_in_data), .in_valid(z_in_valid), .in_last(z_in_last),
    .in_ready(z_in_ready), .gnt(z_gnt), .sym_data(z_sym_data), .sym_valid(z_sym_valid),
    .sym_ready(z_sym_ready), .busy(z_busy), .timeout_err(z_timeout_err)
  );

  function automatic logic [9:0] frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_last = '0; in_data = '0; sym_ready = 1'b0;
    z_in_valid = '0; z_in_last = '0; z_in_data = '0; z_sym_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    cyc();
    n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    n_cmp++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
    n_cmp++; if (sym_data !== 10'h000) begin n_err++; $display("FAIL reset_sym_data: got %h want 000", sym_data); end
    n_cmp++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_busy_tmo: got %b%b want 00", busy, timeout_err); end
    n_cmp++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL reset_in_ready: got %b want 000", in_ready); end
    rst = 1'b1;
    cyc();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_no_req: busy %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int k;
    do_reset();
    sym_ready = 1'b1;
    in_valid = 3'b001; in_data[7:0] = 8'hA5; in_last = 3'b000;
    #1;
    n_cmp++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL basic_idle_ready: got %b want 000", in_ready); end
    cyc();
    n_cmp++; if (gnt !== 3'b001 || busy !== 1'b1) begin n_err++; $display("FAIL basic_grant: gnt %b busy %b want 001 1", gnt, busy); end
    n_cmp++; if (in_ready !== 3'b001) begin n_err++; $display("FAIL basic_ready: got %b want 001", in_ready); end
    cyc();
    n_cmp++; if (sym_valid !== 1'b1 || sym_data !== 10'h34A) begin n_err++; $display("FAIL basic_sym0: got v=%b %h want 1 34a", sym_valid, sym_data); end
    in_data[7:0] = 8'h3C; in_last = 3'b001;
    #1;
    cyc();
    in_valid = 3'b000; in_last = 3'b000;
    #1;
    n_cmp++; if (sym_valid !== 1'b1 || sym_data !== 10'h278) begin n_err++; $display("FAIL basic_sym1: got v=%b %h want 1 278", sym_valid, sym_data); end
    n_cmp++; if (gnt !== 3'b001 || in_ready !== 3'b000) begin n_err++; $display("FAIL basic_last_hold: gnt %b rdy %b want 001 000", gnt, in_ready); end
    cyc();
    n_cmp++; if (gnt !== 3'b000 || sym_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_exit: gnt %b v %b busy %b want 000 0 1", gnt, sym_valid, busy); end
    k = 0;
    while (busy === 1'b1 && k < 100) begin k++; cyc(); end
    n_cmp++; if (k != GAP) begin n_err++; $display("FAIL basic_gap_len: got %0d want %0d", k, GAP); end
    $display("test_basic done");
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[4];
    int zrun, gi;
    logic [N-1:0] prev_g;
    logic [7:0] eb;
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;
    do_reset();
    in_data = {8'h32, 8'h21, 8'h10}; in_last = 3'b111; in_valid = 3'b111; sym_ready = 1'b1;
    zrun = 0; prev_g = '0; gi = -1;
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      cyc();
      if (gnt !== 3'b000 && prev_g === 3'b000) begin
        gi = onehot_idx(gnt);
        order.push_back(gi);
        if (order.size() > 1) begin
          n_cmp++; if (zrun != GAP + 1) begin n_err++; $display("FAIL rr_gap: idle run %0d want %0d", zrun, GAP + 1); end
        end
      end
      if (gnt === 3'b000) zrun++; else zrun = 0;
      if (sym_valid && sym_ready) begin
        eb = 8'(16 + 17 * gi);
        n_cmp++; if (sym_data !== frame(eb)) begin n_err++; $display("FAIL rr_sym: got %h want %h", sym_data, frame(eb)); end
      end
      prev_g = gnt;
    end
    n_cmp++;
    if (order.size() != 4) begin
      n_err++; $display("FAIL rr_count: got %0d grants want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (order[i] != exp_order[i]) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]); end
      end
    end
    in_valid = 3'b000;
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    logic [7:0] bs [3];
    logic [9:0] rx[$];
    int p, stall;
    bit stall_done, tmo_seen;
    bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33;
    do_reset();
    p = 0; stall = 0; stall_done = 0; tmo_seen = 0;
    for (int c = 0; c < 80 && rx.size() < 3; c++) begin
      cyc();
      if (!stall_done && sym_valid && sym_data === frame(8'h22)) begin
        if (stall < 5) begin sym_ready = 1'b0; stall++; end
        else begin sym_ready = 1'b1; stall_done = 1; end
      end else begin
        sym_ready = 1'b1;
      end
      in_valid = (p < 3) ? 3'b010 : 3'b000;
      in_data = {8'h00, bs[p % 3], 8'h00};
      in_last = (p == 2) ? 3'b010 : 3'b000;
      #1;
      if (timeout_err) tmo_seen = 1;
      if (!sym_ready) begin
        n_cmp++; if (sym_valid !== 1'b1 || sym_data !== frame(8'h22)) begin n_err++; $display("FAIL bp_hold: got v=%b %h want 1 %h", sym_valid, sym_data, frame(8'h22)); end
        n_cmp++; if (in_ready !== 3'b000 || gnt !== 3'b010) begin n_err++; $display("FAIL bp_ready: rdy %b gnt %b want 000 010", in_ready, gnt); end
      end
      if (in_valid[1] && in_ready[1]) p++;
      if (sym_valid && sym_ready) rx.push_back(sym_data);
    end
    n_cmp++; if (stall != 5) begin n_err++; $display("FAIL bp_stall_cycles: got %0d want 5", stall); end
    n_cmp++; if (tmo_seen) begin n_err++; $display("FAIL bp_timeout: got timeout_err 1 want 0"); end
    n_cmp++;
    if (rx.size() != 3) begin
      n_err++; $display("FAIL bp_count: got %0d symbols want 3", rx.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (rx[i] !== frame(bs[i])) begin n_err++; $display("FAIL bp_sym[%0d]: got %h want %h", i, rx[i], frame(bs[i])); end
      end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_timeout();
    int p, d, k;
    bit started, done;
    do_reset();
    sym_ready = 1'b1; in_valid = 3'b100; in_data = {8'h5A, 16'h0000}; in_last = 3'b000;
    p = 0; d = 0; started = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      cyc();
      if (started) d++;
      if (timeout_err === 1'b1) begin
        done = 1;
        n_cmp++; if (d != TMO) begin n_err++; $display("FAIL tmo_delay: got %0d want %0d", d, TMO); end
        n_cmp++; if (gnt !== 3'b000 || busy !== 1'b1) begin n_err++; $display("FAIL tmo_state: gnt %b busy %b want 000 1", gnt, busy); end
      end else begin
        if (p > 0) in_valid = 3'b000;
        #1;
        if (in_valid[2] && in_ready[2]) p++;
        if (sym_valid && sym_ready) begin
          started = 1; d = -1;
          n_cmp++; if (sym_data !== frame(8'h5A)) begin n_err++; $display("FAIL tmo_sym: got %h want %h", sym_data, frame(8'h5A)); end
        end
      end
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL tmo_missing: got no timeout_err want pulse"); end
    cyc();
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse_width: got %b want 0", timeout_err); end
    k = 0;
    while (busy === 1'b1 && k < 100) begin k++; cyc(); end
    n_cmp++; if (k != GAP - 1) begin n_err++; $display("FAIL tmo_gap: got %0d want %0d", k, GAP - 1); end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    int p;
    bit hit, leak;
    do_reset();
    sym_ready = 1'b1; p = 0; hit = 0; leak = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      cyc();
      if (sym_valid && sym_data === frame(8'h02)) begin
        hit = 1;
        sym_ready = 1'b0; rst = 1'b0; in_valid = 3'b011;
        #1;
        n_cmp++; if (sym_valid !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_clear: v %b gnt %b busy %b want 0 000 0", sym_valid, gnt, busy); end
      end else begin
        in_valid = (p < 4) ? 3'b001 : 3'b000;
        in_data = {16'h0000, 8'(p + 1)};
        in_last = (p == 3) ? 3'b001 : 3'b000;
        #1;
        if (in_valid[0] && in_ready[0]) p++;
      end
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL rstmid_reach: got no second symbol want one"); end
    in_data = {8'h00, 8'h77, 8'h66}; in_last = 3'b011; sym_ready = 1'b1;
    repeat (3) begin cyc(); if (sym_valid !== 1'b0) leak = 1; end
    n_cmp++; if (leak) begin n_err++; $display("FAIL rstmid_leak: got sym_valid 1 in reset want 0"); end
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (gnt !== 3'b000) break;
    end
    n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rstmid_first: gnt %b want 001", gnt); end
    in_valid = 3'b000;
    $display("test_reset_mid done");
  endtask

  task automatic test_no_gap();
    int p, syms, idle_between;
    bit counting;
    do_reset();
    z_sym_ready = 1'b1; z_in_last = 3'b010;
    p = 0; syms = 0; idle_between = 0; counting = 0;
    for (int c = 0; c < 60 && syms < 2; c++) begin
      cyc();
      z_in_valid = (p < 2) ? 3'b010 : 3'b000;
      z_in_data = {8'h00, 8'(8'h81 + p), 8'h00};
      #1;
      if (counting && z_busy === 1'b0) idle_between++;
      if (z_in_valid[1] && z_in_ready[1]) p++;
      if (z_sym_valid && z_sym_ready) begin
        n_cmp++; if (z_sym_data !== frame(8'(8'h81 + syms)) || z_gnt !== 3'b010) begin n_err++; $display("FAIL nogap_sym%0d: got %h gnt %b want %h 010", syms, z_sym_data, z_gnt, frame(8'(8'h81 + syms))); end
        syms++;
        counting = 1;
      end
    end
    n_cmp++; if (syms != 2) begin n_err++; $display("FAIL nogap_count: got %0d want 2", syms); end
    n_cmp++; if (idle_between != 1) begin n_err++; $display("FAIL nogap_idle: got %0d idle cycles want 1", idle_between); end
    z_in_valid = 3'b000;
    $display("test_no_gap done");
  endtask

  task automatic test_random();
    logic [7:0] pd [N][16];
    bit pl [N][16];
    bit ps [N][16];
    int plen[N], ptr[N];
    int pk_len[N][4];
    logic [9:0] exp_sym[$];
    int exp_req[$];
    logic [9:0] e, prev_sym;
    logic [N-1:0] eg;
    int r, base, zrun, npk;
    bit prev_hold, first_seen, bubble;
    for (int i = 0; i < N; i++) begin
      plen[i] = 0; ptr[i] = 0;
      for (int k = 0; k < 4; k++) begin
        pk_len[i][k] = $urandom_range(1, 4);
        for (int b = 0; b < pk_len[i][k]; b++) begin
          pd[i][plen[i]] = 8'($urandom);
          pl[i][plen[i]] = (b == pk_len[i][k] - 1);
          ps[i][plen[i]] = (b == 0);
          plen[i]++;
        end
      end
    end
    // Every requester always has a packet queued, so arbitration rotates 0,1,2,...
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        base = 0;
        for (int j = 0; j < k; j++) base += pk_len[i][j];
        for (int b = 0; b < pk_len[i][k]; b++) begin
          exp_sym.push_back(frame(pd[i][base + b]));
          exp_req.push_back(i);
        end
      end
    end
    npk = exp_sym.size();
    do_reset();
    prev_hold = 0; prev_sym = '0; zrun = 0; first_seen = 0;
    for (int c = 0; c < 3000 && exp_sym.size() > 0; c++) begin
      cyc();
      sym_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (ptr[i] < plen[i]) begin
          bubble = gnt[i] && !ps[i][ptr[i]] && ($urandom_range(0, 3) == 0);
          in_valid[i] = !bubble;
          in_data[i*8 +: 8] = pd[i][ptr[i]];
          in_last[i] = pl[i][ptr[i]];
        end else begin
          in_valid[i] = 1'b0;
          in_data[i*8 +: 8] = 8'($urandom);
          in_last[i] = 1'($urandom);
        end
      end
      #1;
      if (prev_hold) begin
        n_cmp++; if (sym_valid !== 1'b1 || sym_data !== prev_sym) begin n_err++; $display("FAIL rnd_hold: got v=%b %h want 1 %h", sym_valid, sym_data, prev_sym); end
      end
      n_cmp++; if ((in_ready & ~gnt) !== 3'b000) begin n_err++; $display("FAIL rnd_ready_mask: rdy %b gnt %b want no ready outside grant", in_ready, gnt); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rnd_timeout: got 1 want 0"); end
      if (gnt === 3'b000) begin
        zrun++;
      end else begin
        if (zrun > 0 && first_seen) begin
          n_cmp++; if (zrun != GAP + 1) begin n_err++; $display("FAIL rnd_gap: idle run %0d want %0d", zrun, GAP + 1); end
        end
        first_seen = 1; zrun = 0;
      end
      if (sym_valid && sym_ready) begin
        e = exp_sym.pop_front();
        r = exp_req.pop_front();
        eg = 3'(1 << r);
        n_cmp++; if (sym_data !== e) begin n_err++; $display("FAIL rnd_sym: got %h want %h", sym_data, e); end
        n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL rnd_gnt: got %b want %b", gnt, eg); end
      end
      for (int i = 0; i < N; i++) if (in_valid[i] && in_ready[i]) ptr[i]++;
      prev_hold = sym_valid && !sym_ready;
      prev_sym = sym_data;
    end
    n_cmp++; if (exp_sym.size() != 0) begin n_err++; $display("FAIL rnd_drain: %0d symbols undelivered want 0", exp_sym.size()); end
    idle_inputs();
    $display("test_random done: %0d symbols", npk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_no_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
